// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the two-requester APB arbiter.
package apb_arb_pkg;

  localparam int unsigned APB_ADDR_W = 5;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_SEL_W  = 2;

  localparam logic [APB_SEL_W-1:0] PSEL_S1 = 2'd1;
  localparam logic [APB_SEL_W-1:0] PSEL_S2 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_SEL_W-1:0]  sel;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } arb_cmd_t;

  // Only the two populated slaves may be addressed.
  function automatic logic sel_legal(input logic [APB_SEL_W-1:0] sel);
    return (sel == PSEL_S1) || (sel == PSEL_S2);
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Two-way round-robin picker; the last-grant pointer favours the other requester on a tie.
module apb_rr_picker (
  input  logic       pclk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 = requester 1 was granted last, so requester 0 wins the first tie.
  logic last;

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      last <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB bridge between two requesters: round-robin pick, command latch, one transfer, done pulse.
// Optional watchdog on the transfer phase: define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  Reset,
  input  logic                  req0,
  input  logic                  req0_write,
  input  logic [APB_SEL_W-1:0]  req0_sel,
  input  logic [APB_ADDR_W-1:0] req0_addr,
  input  logic [APB_DATA_W-1:0] req0_wdata,
  input  logic                  req1,
  input  logic                  req1_write,
  input  logic [APB_SEL_W-1:0]  req1_sel,
  input  logic [APB_ADDR_W-1:0] req1_addr,
  input  logic [APB_DATA_W-1:0] req1_wdata,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  err0,
  output logic                  err1,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  transfer_Master,
  output logic                  penable_Master,
  output logic                  pwrite_Master,
  output logic [APB_SEL_W-1:0]  Psel,
  output logic [APB_ADDR_W-1:0] write_paddr_Master,
  output logic [APB_ADDR_W-1:0] read_paddr_Master,
  output logic [APB_DATA_W-1:0] write_data_Master,
  input  logic                  br_penable,
  input  logic                  pready_slave,
  input  logic [APB_DATA_W-1:0] prdata
);

  arb_state_e            state, state_next;
  arb_cmd_t              cmd, cmd_next;
  logic                  win, win_next;
  logic [APB_DATA_W-1:0] rdata_next;
  logic                  err_next;
  logic                  advance;
  logic [1:0]            grant;
  logic                  xfer_q;
  arb_cmd_t              cand;

  apb_rr_picker u_picker (
    .pclk    (pclk),
    .Reset   (Reset),
    .req     ({req1, req0}),
    .advance (advance),
    .grant   (grant)
  );

  assign cand = grant[1] ? arb_cmd_t'{req1_write, req1_sel, req1_addr, req1_wdata}
                         : arb_cmd_t'{req0_write, req0_sel, req0_addr, req0_wdata};

  // Grant is the only decoded output; it must also read 0 while Reset is held.
  assign gnt0 = (state == IDLE) && grant[0] && !Reset;
  assign gnt1 = (state == IDLE) && grant[1] && !Reset;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (state != XFER) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end
`endif

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_next   = cmd;
    win_next   = win;
    rdata_next = rsp_rdata;
    err_next   = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          advance  = 1'b1;
          win_next = grant[1];
          cmd_next = cand;
          if (sel_legal(cand.sel)) begin
            state_next = XFER;
          end else begin
            // No slave to select: answer with an error instead of touching the bus.
            state_next = DONE;
            err_next   = 1'b1;
            rdata_next = '0;
          end
        end
      end
      XFER: begin
        if (br_penable && pready_slave) begin
          state_next = DONE;
          rdata_next = cmd.write ? '0 : prdata;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_next = DONE;
          err_next   = 1'b1;
          rdata_next = '0;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      cmd       <= '0;
      win       <= 1'b0;
      xfer_q    <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cmd       <= cmd_next;
      win       <= win_next;
      xfer_q    <= (state_next == XFER);
      done0     <= (state_next == DONE) && !win_next;
      done1     <= (state_next == DONE) && win_next;
      err0      <= err_next && !win_next;
      err1      <= err_next && win_next;
      rsp_rdata <= rdata_next;
    end
  end

  assign transfer_Master    = xfer_q;
  assign penable_Master     = xfer_q;
  assign pwrite_Master      = cmd.write;
  assign Psel               = cmd.sel;
  assign write_paddr_Master = cmd.addr;
  assign read_paddr_Master  = cmd.addr;
  assign write_data_Master  = cmd.wdata;

endmodule
